// File: rtl/prf_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prf_read_arbiter_pkg
//  Description : Shared sizing constants and types for the PRF read arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package prf_read_arbiter_pkg;

  localparam int PR_COUNT             = 128;
  localparam int LOG_PR_COUNT         = $clog2(PR_COUNT);
  localparam int PRF_BANK_COUNT       = 4;
  localparam int LOG_PRF_BANK_COUNT   = $clog2(PRF_BANK_COUNT);
  localparam int PRF_READ_PORT_COUNT  = 2;
  localparam int PRF_RR_COUNT         = 14;
  localparam int LOG_PRF_RR_COUNT     = $clog2(PRF_RR_COUNT);
  localparam int PRF_BANK_INDEX_WIDTH = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  localparam int XLEN                 = 32;

  // Requestor id carried down the issue/return pipeline
  typedef logic [LOG_PRF_RR_COUNT-1:0] rr_id_t;
  // Register index within one bank (physical register with bank bits removed)
  typedef logic [PRF_BANK_INDEX_WIDTH-1:0] bank_index_t;

endpackage
`default_nettype wire

// File: rtl/prf_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prf_bank_rr_arbiter
//  Description : Picks up to two requestors out of N in round-robin order,
//                starting at an internal pointer. grant0 is the first hit at
//                or after the pointer, grant1 the next hit after it.
//  Revision    : 1.0  initial release
// ============================================================================
module prf_bank_rr_arbiter #(
  parameter int N     = 14,
  parameter int LOG_N = $clog2(N)
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant0,
  output logic [N-1:0] grant1
);

  logic [LOG_N-1:0] r_ptr;
  logic [LOG_N-1:0] w_idx;
  logic [LOG_N-1:0] w_last;
  logic [LOG_N-1:0] w_ptr_next;
  logic             w_found0;
  logic             w_found1;

  // Scan all N positions from the pointer upward (wrapping N-1 -> 0), taking the first two hits
  always_comb begin
    grant0   = '0;
    grant1   = '0;
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_last   = r_ptr;
    w_idx    = r_ptr;
    for (int off = 0; off < N; off++) begin
      if (req[w_idx]) begin
        if (!w_found0) begin
          grant0[w_idx] = 1'b1;
          w_found0      = 1'b1;
          w_last        = w_idx;
        end else if (!w_found1) begin
          grant1[w_idx] = 1'b1;
          w_found1      = 1'b1;
          w_last        = w_idx;
        end
      end
      w_idx = (w_idx == LOG_N'(N-1)) ? '0 : w_idx + LOG_N'(1);
    end
    // Pointer moves just past the last winner; wraps explicitly so it never leaves 0..N-1
    w_ptr_next = (w_last == LOG_N'(N-1)) ? '0 : w_last + LOG_N'(1);
  end

  // Pointer advances only when this bank granted something
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_ptr <= '0;
    end else if (w_found0) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prf_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prf_read_arbiter
//  Description : Routes PRF read requestors onto banked read ports. Grants are
//                combinational, bank addresses registered (stage 1), returned
//                data is steered back to the requestor via stage-2 ids.
//  Revision    : 1.0  initial release
// ============================================================================
module prf_read_arbiter
  import prf_read_arbiter_pkg::*;
(
  input  logic                                                                   CLK,
  input  logic                                                                   nRST,
  input  logic [PRF_RR_COUNT-1:0]                                                req_valid_by_rr,
  input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                              req_pr_by_rr,
  output logic [PRF_RR_COUNT-1:0]                                                req_ack_by_rr,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                     bank_read_valid_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][PRF_BANK_INDEX_WIDTH-1:0] bank_read_index_by_bank_by_port,
  input  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][XLEN-1:0]           bank_read_data_by_bank_by_port,
  output logic [PRF_RR_COUNT-1:0]                                                resp_valid_by_rr,
  output logic [PRF_RR_COUNT-1:0][XLEN-1:0]                                      resp_data_by_rr
);

  logic        [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][PRF_RR_COUNT-1:0] w_grant;
  logic        [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   w_issue_valid;
  bank_index_t [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   w_issue_index;
  rr_id_t      [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   w_issue_id;

  logic        [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   r_s1_valid;
  bank_index_t [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   r_s1_index;
  rr_id_t      [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   r_s1_id;
  logic        [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   r_s2_valid;
  rr_id_t      [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                   r_s2_id;

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    logic [PRF_RR_COUNT-1:0] w_cand;

    // Candidates for this bank: valid requests whose low PR bits select it; nothing wins in reset
    always_comb begin
      w_cand = '0;
      for (int rr = 0; rr < PRF_RR_COUNT; rr++) begin
        w_cand[rr] = nRST && req_valid_by_rr[rr] &&
                     (req_pr_by_rr[rr][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
      end
    end

    prf_bank_rr_arbiter #(
      .N     (PRF_RR_COUNT),
      .LOG_N (LOG_PRF_RR_COUNT)
    ) u_arb (
      .CLK    (CLK),
      .nRST   (nRST),
      .req    (w_cand),
      .grant0 (w_grant[b][0]),
      .grant1 (w_grant[b][1])
    );
  end

  // Fold one-hot grants into acks plus per-port valid/index/id for the issue stage
  always_comb begin
    req_ack_by_rr = '0;
    w_issue_valid = '0;
    w_issue_index = '0;
    w_issue_id    = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
        w_issue_valid[b][p] = |w_grant[b][p];
        req_ack_by_rr       = req_ack_by_rr | w_grant[b][p];
        for (int rr = 0; rr < PRF_RR_COUNT; rr++) begin
          if (w_grant[b][p][rr]) begin
            w_issue_id[b][p]    = rr_id_t'(rr);
            w_issue_index[b][p] = req_pr_by_rr[rr][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          end
        end
      end
    end
  end

  // Stage 1 drives the bank address; stage 2 lines up with the returning bank data
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_s1_valid <= '0;
      r_s1_index <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= '0;
      r_s2_id    <= '0;
    end else begin
      r_s1_valid <= w_issue_valid;
      r_s1_index <= w_issue_index;
      r_s1_id    <= w_issue_id;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
    end
  end

  assign bank_read_valid_by_bank_by_port = r_s1_valid;
  assign bank_read_index_by_bank_by_port = r_s1_index;

  // Steer each valid stage-2 port's data to its requestor; at most one port matches a given id
  always_comb begin
    resp_valid_by_rr = '0;
    resp_data_by_rr  = '0;
    for (int rr = 0; rr < PRF_RR_COUNT; rr++) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
          if (r_s2_valid[b][p] && (r_s2_id[b][p] == rr_id_t'(rr))) begin
            resp_valid_by_rr[rr] = 1'b1;
            resp_data_by_rr[rr]  = resp_data_by_rr[rr] | bank_read_data_by_bank_by_port[b][p];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prf_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prf_read_arbiter
//  Description : Directed bench for prf_read_arbiter with a bank emulator and
//                a per-cycle reference model of grants, issue and return.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prf_read_arbiter;
  import prf_read_arbiter_pkg::*;

  logic                         clk = 1'b0;
  logic                         nRST;
  logic [13:0]                  req_valid_by_rr;
  logic [13:0][6:0]             req_pr_by_rr;
  logic [13:0]                  req_ack_by_rr;
  logic [3:0][1:0]              bank_read_valid_by_bank_by_port;
  logic [3:0][1:0][4:0]         bank_read_index_by_bank_by_port;
  logic [3:0][1:0][31:0]        bank_read_data_by_bank_by_port;
  logic [13:0]                  resp_valid_by_rr;
  logic [13:0][31:0]            resp_data_by_rr;

  int n_checks = 0;
  int n_errors = 0;

  prf_read_arbiter dut (
    .CLK                             (clk),
    .nRST                            (nRST),
    .req_valid_by_rr                 (req_valid_by_rr),
    .req_pr_by_rr                    (req_pr_by_rr),
    .req_ack_by_rr                   (req_ack_by_rr),
    .bank_read_valid_by_bank_by_port (bank_read_valid_by_bank_by_port),
    .bank_read_index_by_bank_by_port (bank_read_index_by_bank_by_port),
    .bank_read_data_by_bank_by_port  (bank_read_data_by_bank_by_port),
    .resp_valid_by_rr                (resp_valid_by_rr),
    .resp_data_by_rr                 (resp_data_by_rr)
  );

  always #5 clk = ~clk;

  // Storage contents of the register file as seen by the bench
  function automatic logic [31:0] pr_data(input int pr);
    logic [6:0] p7;
    p7 = 7'(pr);
    if (pr == 'h25) return 32'hDEADBEEF;
    return {8'h5A, 9'd0, p7, 1'b0, ~p7};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Bank emulator: data for the address presented this cycle appears next cycle
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      for (int p = 0; p < 2; p++)
        bank_read_data_by_bank_by_port[b][p] <= bank_read_valid_by_bank_by_port[b][p] ?
          pr_data(int'(bank_read_index_by_bank_by_port[b][p]) * 4 + b) : 32'($urandom);
  end

  // Reference model: pointers, issued reads per bank port, pending responses per requestor
  int         m_ptr  [4];
  bit         m_s1_v [4][2];
  int         m_s1_pr[4][2];
  int         m_s1_rr[4][2];
  bit         m_s2_v [14];
  logic [31:0] m_s2_d[14];
  bit         started = 1'b0;

  always @(negedge clk) begin
    int win [4][2];
    int nwin[4];
    int r;
    logic [13:0] eack;
    eack = '0;
    for (int b = 0; b < 4; b++) nwin[b] = 0;
    if (nRST === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 14; k++) begin
          r = (m_ptr[b] + k) % 14;
          if (req_valid_by_rr[r] && int'(req_pr_by_rr[r]) % 4 == b && nwin[b] < 2) begin
            win[b][nwin[b]] = r;
            nwin[b]++;
            eack[r] = 1'b1;
          end
        end
      end
    end
    chk("ack", 64'(req_ack_by_rr), 64'(eack));
    if (started) begin
      for (int b = 0; b < 4; b++)
        for (int p = 0; p < 2; p++) begin
          chk("rd_valid", 64'(bank_read_valid_by_bank_by_port[b][p]), 64'(m_s1_v[b][p]));
          if (m_s1_v[b][p])
            chk("rd_index", 64'(bank_read_index_by_bank_by_port[b][p]), 64'(m_s1_pr[b][p] / 4));
        end
      for (int i = 0; i < 14; i++) begin
        chk("resp_valid", 64'(resp_valid_by_rr[i]), 64'(m_s2_v[i]));
        chk("resp_data", 64'(resp_data_by_rr[i]), 64'(m_s2_v[i] ? m_s2_d[i] : 32'd0));
      end
    end
    if (nRST !== 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        m_ptr[b] = 0;
        for (int p = 0; p < 2; p++) m_s1_v[b][p] = 1'b0;
      end
      for (int i = 0; i < 14; i++) begin m_s2_v[i] = 1'b0; m_s2_d[i] = '0; end
      started = 1'b1;
    end else if (started) begin
      for (int i = 0; i < 14; i++) begin m_s2_v[i] = 1'b0; m_s2_d[i] = '0; end
      for (int b = 0; b < 4; b++)
        for (int p = 0; p < 2; p++)
          if (m_s1_v[b][p]) begin
            m_s2_v[m_s1_rr[b][p]] = 1'b1;
            m_s2_d[m_s1_rr[b][p]] = pr_data(m_s1_pr[b][p]);
          end
      for (int b = 0; b < 4; b++) begin
        for (int p = 0; p < 2; p++) begin
          m_s1_v[b][p] = (p < nwin[b]);
          if (p < nwin[b]) begin
            m_s1_rr[b][p] = win[b][p];
            m_s1_pr[b][p] = int'(req_pr_by_rr[win[b][p]]);
          end
        end
        if (nwin[b] > 0) m_ptr[b] = (win[b][nwin[b]-1] + 1) % 14;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid_by_rr = '0;
    req_pr_by_rr    = '0;
  endtask

  task automatic set_req(input int rr, input int pr);
    req_valid_by_rr[rr] = 1'b1;
    req_pr_by_rr[rr]    = 7'(pr);
  endtask

  initial begin
    logic [13:0] seen;
    nRST = 1'b0;
    clear_reqs();
    tick();
    tick();
    nRST = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      tick();
      #2;
      chk("idle_ack", 64'(req_ack_by_rr), 64'd0);
      chk("idle_rd_valid", 64'(bank_read_valid_by_bank_by_port), 64'd0);
      chk("idle_resp_valid", 64'(resp_valid_by_rr), 64'd0);
    end

    // Single read: rr3 reads pr 0x25 (bank 1, index 9)
    tick(); set_req(3, 'h25); #2;
    chk("single_ack", 64'(req_ack_by_rr), 64'h8);
    tick(); clear_reqs(); #2;
    chk("single_rd_valid", 64'(bank_read_valid_by_bank_by_port), 64'h04);
    chk("single_rd_index", 64'(bank_read_index_by_bank_by_port[1][0]), 64'd9);
    tick(); #2;
    chk("single_resp_valid", 64'(resp_valid_by_rr), 64'h8);
    chk("single_resp_data", 64'(resp_data_by_rr[3]), 64'hDEADBEEF);

    // Three-way conflict on bank 0 from ptr 0
    tick(); set_req(2, 'h10); set_req(5, 'h20); set_req(9, 'h30); #2;
    chk("conflict_ack0", 64'(req_ack_by_rr), 64'h24);
    tick(); clear_reqs(); set_req(9, 'h30); #2;
    chk("conflict_ack1", 64'(req_ack_by_rr), 64'h200);
    chk("conflict_idx_p0", 64'(bank_read_index_by_bank_by_port[0][0]), 64'd4);
    chk("conflict_idx_p1", 64'(bank_read_index_by_bank_by_port[0][1]), 64'd8);
    tick(); clear_reqs(); #2;
    chk("conflict_rd_valid", 64'(bank_read_valid_by_bank_by_port), 64'h01);
    chk("conflict_idx_retry", 64'(bank_read_index_by_bank_by_port[0][0]), 64'd12);
    chk("conflict_resp0", 64'(resp_valid_by_rr), 64'h24);
    tick(); #2;
    chk("conflict_resp1", 64'(resp_valid_by_rr), 64'h200);
    chk("conflict_data", 64'(resp_data_by_rr[9]), 64'(pr_data('h30)));

    // Wraparound on bank 2: rr11 alone moves ptr to 12
    tick(); set_req(11, 'h0A); #2;
    chk("wrap_setup_ack", 64'(req_ack_by_rr), 64'h800);
    tick(); clear_reqs(); set_req(13, 'h06); set_req(1, 'h0E); #2;
    chk("wrap_ack", 64'(req_ack_by_rr), 64'h2002);
    tick(); clear_reqs(); set_req(1, 'h12); set_req(3, 'h16); #2;
    chk("wrap_p0_rr13", 64'(bank_read_index_by_bank_by_port[2][0]), 64'd1);
    chk("wrap_p1_rr1", 64'(bank_read_index_by_bank_by_port[2][1]), 64'd3);
    chk("wrap_ptr2_ack", 64'(req_ack_by_rr), 64'h000A);
    tick(); clear_reqs(); #2;
    chk("wrap_ptr2_p0_rr3", 64'(bank_read_index_by_bank_by_port[2][0]), 64'd5);
    chk("wrap_ptr2_p1_rr1", 64'(bank_read_index_by_bank_by_port[2][1]), 64'd4);

    // Full load: every requestor asks every cycle
    seen = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int rr = 0; rr < 14; rr++) set_req(rr, rr * 4 + rr % 4);
      #2;
      chk("full_ack_count", 64'($countones(req_ack_by_rr)), 64'd8);
      seen = seen | req_ack_by_rr;
      if (c == 3) chk("full_all_acked", 64'(seen), 64'h3FFF);
    end
    tick(); clear_reqs();
    tick(); tick(); tick();

    // Reset mid-flight
    set_req(0, 'h01); set_req(4, 'h13); set_req(10, 'h04); #2;
    chk("rst_pre_ack", 64'(req_ack_by_rr), 64'h411);
    tick(); nRST = 1'b0; #2;
    chk("rst_ack_forced", 64'(req_ack_by_rr), 64'd0);
    chk("rst_inflight", 64'(bank_read_valid_by_bank_by_port), 64'h45);
    tick(); nRST = 1'b1; clear_reqs(); #2;
    chk("rst_resp_dropped", 64'(resp_valid_by_rr), 64'd0);
    chk("rst_rd_valid", 64'(bank_read_valid_by_bank_by_port), 64'd0);
    tick(); #2;
    chk("rst_resp_dropped2", 64'(resp_valid_by_rr), 64'd0);
    tick(); set_req(12, 'h30); set_req(0, 'h00); set_req(6, 'h18); #2;
    chk("rst_ptr_zero_ack", 64'(req_ack_by_rr), 64'h41);
    tick(); clear_reqs(); #2;
    chk("rst_ptr_p0", 64'(bank_read_index_by_bank_by_port[0][0]), 64'd0);
    chk("rst_ptr_p1", 64'(bank_read_index_by_bank_by_port[0][1]), 64'd6);
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
